// File: rtl/net_tx_frame_arbiter_pkg.sv
// Shared types and constants for the tx frame arbiter and its round-robin picker.
// No logic here, so no latency.
// No flow control lives here; it is all in the modules that import this package.
package net_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PASS  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_MAX = 4;
    localparam int STAT_W      = 16;
    localparam int MAX_LEN_DEF = 1514;

    // Width of an index into a vector of n requesters; a single bit is kept even when n==1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/net_tx_frame_arbiter_if.sv
// Groups the NUM_REQ-wide requester AXI-Stream bundle and the single TEMAC-facing stream.
// No logic here, so no latency.
// Both sides use plain AXIS valid/ready; the arbiter takes the slave modport.
interface net_tx_frame_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    logic [NUM_REQ*8-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]   s_axis_tvalid;
    logic [NUM_REQ-1:0]   s_axis_tlast;
    logic [NUM_REQ-1:0]   s_axis_tready;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;

    // Arbiter view: it consumes requester streams and produces the TEMAC stream.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    // Environment view: requesters and TEMAC together.
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/net_tx_frame_arbiter_rr_picker.sv
// Round-robin picker: first requester after i_last (wrapping) wins, one-hot result.
// Purely combinational, zero latency.
// No flow control; the caller decides when a pick is committed.
module net_rr_picker
    import net_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_pick,
    output logic             o_vld
);

    // Scan last+1, last+2, ... modulo N and keep the first hit.
    always_comb begin
        o_pick = '0;
        o_vld  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!o_vld && i_req[(int'(i_last) + k) % N]) begin
                o_pick[(int'(i_last) + k) % N] = 1'b1;
                o_vld                          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/net_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the TEMAC tx stream; truncates frames beyond MAX_LEN and drains the rest.
// 1 cycle arbitration in IDLE, then zero-latency combinational pass-through; one IDLE bubble between frames.
// Owner's ready mirrors m_axis_tready in PASS, forced 1 in DRAIN; non-owners see ready 0. Optional counters: ARB_STATS_EN.
module net_tx_frame_arbiter
    import net_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                      net_axis_clk,
    input  logic                      net_axis_rst,
    net_tx_frame_arbiter_if.slave     bus,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      trunc_pulse,
    output logic [NUM_REQ*STAT_W-1:0] stat_frames,
    output logic [NUM_REQ*STAT_W-1:0] stat_truncs
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last_grant;
    logic [NUM_REQ-1:0] r_grant;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic               r_trunc_pulse;

    logic [NUM_REQ-1:0] w_pick;
    logic               w_pick_vld;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_sel_vld;
    logic               w_sel_last;
    logic [7:0]         w_sel_dat;
    logic               w_at_max;
    logic               w_pass_end;
    logic               w_pass_trunc;
    logic               w_pass_hs;
    logic               w_drain_end;

    net_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req  (bus.s_axis_tvalid),
        .i_last (r_last_grant),
        .o_pick (w_pick),
        .o_vld  (w_pick_vld)
    );

    // Convert the one-hot pick to an index for the data muxes.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = IDX_W'(i);
            end
        end
    end

    // Select the owner's stream; the last allowed beat is the one after MAX_LEN-1 accepted beats.
    always_comb begin
        w_sel_vld  = bus.s_axis_tvalid[r_owner];
        w_sel_last = bus.s_axis_tlast[r_owner];
        w_sel_dat  = bus.s_axis_tdata[int'(r_owner)*8 +: 8];
        w_at_max   = (r_byte_cnt == CNT_W'(MAX_LEN - 1));
    end

    // Next-state and stream outputs; a real tlast takes priority over the length limit.
    always_comb begin
        w_state_nxt       = r_state;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = 8'd0;
        bus.m_axis_tlast  = 1'b0;
        bus.s_axis_tready = '0;
        w_pass_end        = 1'b0;
        w_pass_trunc      = 1'b0;
        w_pass_hs         = 1'b0;
        w_drain_end       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ARB_PASS;
                end
            end
            ARB_PASS: begin
                bus.m_axis_tvalid          = w_sel_vld;
                bus.m_axis_tdata           = w_sel_dat;
                bus.m_axis_tlast           = w_sel_last | w_at_max;
                bus.s_axis_tready[r_owner] = bus.m_axis_tready;
                if (w_sel_vld && bus.m_axis_tready) begin
                    w_pass_hs = 1'b1;
                    if (w_sel_last) begin
                        w_pass_end  = 1'b1;
                        w_state_nxt = ARB_IDLE;
                    end else if (w_at_max) begin
                        w_pass_trunc = 1'b1;
                        w_state_nxt  = ARB_DRAIN;
                    end
                end
            end
            ARB_DRAIN: begin
                bus.s_axis_tready[r_owner] = 1'b1;
                if (w_sel_vld && w_sel_last) begin
                    w_drain_end = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge net_axis_clk) begin
        if (net_axis_rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner, grant, round-robin pointer, byte count and truncation pulse.
    always_ff @(posedge net_axis_clk) begin
        if (net_axis_rst) begin
            r_owner       <= '0;
            r_last_grant  <= IDX_W'(NUM_REQ - 1);
            r_grant       <= '0;
            r_byte_cnt    <= '0;
            r_trunc_pulse <= 1'b0;
        end else begin
            r_trunc_pulse <= w_pass_trunc;
            if (r_state == ARB_IDLE) begin
                r_byte_cnt <= '0;
                if (w_pick_vld) begin
                    r_grant <= w_pick;
                    r_owner <= w_pick_idx;
                end
            end else if (w_pass_end || w_drain_end) begin
                r_grant      <= '0;
                r_last_grant <= r_owner;
                r_byte_cnt   <= '0;
            end else if (w_pass_hs) begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
        end
    end

    assign grant       = r_grant;
    assign trunc_pulse = r_trunc_pulse;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_frames [NUM_REQ];
    logic [STAT_W-1:0] r_stat_truncs [NUM_REQ];

    // Per-port saturating frame and truncation counters.
    always_ff @(posedge net_axis_clk) begin
        if (net_axis_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_frames[i] <= '0;
                r_stat_truncs[i] <= '0;
            end
        end else begin
            if (w_pass_end && (r_stat_frames[r_owner] != '1)) begin
                r_stat_frames[r_owner] <= r_stat_frames[r_owner] + STAT_W'(1);
            end
            if (w_pass_trunc && (r_stat_truncs[r_owner] != '1)) begin
                r_stat_truncs[r_owner] <= r_stat_truncs[r_owner] + STAT_W'(1);
            end
        end
    end

    // Flatten the counters onto the stat buses, port i at [16i+15:16i].
    always_comb begin
        stat_frames = '0;
        stat_truncs = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_frames[i*STAT_W +: STAT_W] = r_stat_frames[i];
            stat_truncs[i*STAT_W +: STAT_W] = r_stat_truncs[i];
        end
    end
`else
    assign stat_frames = '0;
    assign stat_truncs = '0;
`endif

endmodule

// File: tb/tb_net_tx_frame_arbiter.sv
// Self-checking bench for net_tx_frame_arbiter: scenario table, mid-frame reset, random frames.
// Expected output is derived from per-port frame lists with a round-robin ordering model.
// Sources hold valid/data until handshake; TEMAC ready is randomised per scenario.
module tb_net_tx_frame_arbiter;
    import net_arb_pkg::*;

    localparam int N  = 2;
    localparam int ML = 1514;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    net_tx_frame_arbiter_if #(.NUM_REQ(N)) bus ();
    logic [N-1:0]    grant;
    logic            trunc_pulse;
    logic [N*16-1:0] stat_frames;
    logic [N*16-1:0] stat_truncs;

    net_tx_frame_arbiter #(.NUM_REQ(N), .MAX_LEN(ML)) u_dut (
        .net_axis_clk (clk),
        .net_axis_rst (rst),
        .bus          (bus),
        .grant        (grant),
        .trunc_pulse  (trunc_pulse),
        .stat_frames  (stat_frames),
        .stat_truncs  (stat_truncs)
    );

    int total = 0;
    int bad   = 0;

    // Source byte queues: bits [7:0] data, bit 8 tlast.
    int sq [N][$];
    int mdl_len [N][$];
    int mdl_fid [N][$];
    int fid_ctr [N];
    int exp_port [$];
    int exp_fid  [$];
    int exp_len  [$];
    int exp_sf [N];
    int exp_st [N];
    int exp_tr;

    int mon_fr, mon_bi, out_bytes, trunc_cnt, obs_order, cyc, rdy_pct;
    bit prev_end_hs, prev_trunc_evt;

    typedef struct {
        int len0; int len1; int nfr; int rdy;
        int e_frames; int e_bytes; int e_truncs; int e_order;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [7:0] dat(input int p, input int f, input int i);
        return 8'((p * 101 + f * 37 + i * 13 + (i >> 8)) & 255);
    endfunction

    task automatic load_frame(input int p, input int len);
        int f;
        f = fid_ctr[p];
        fid_ctr[p]++;
        for (int i = 0; i < len; i++) sq[p].push_back(int'(dat(p, f, i)) | ((i == len - 1) ? 256 : 0));
        mdl_len[p].push_back(len);
        mdl_fid[p].push_back(f);
    endtask

    // Round-robin over ports that still have frames, starting after port N-1.
    task automatic build_expected();
        int cl [N][$];
        int cf [N][$];
        int last, len, f, p;
        bit any;
        exp_tr = 0;
        for (int q = 0; q < N; q++) begin
            cl[q] = mdl_len[q];
            cf[q] = mdl_fid[q];
            exp_sf[q] = 0;
            exp_st[q] = 0;
        end
        last = N - 1;
        do begin
            any = 1'b0;
            for (int k = 1; k <= N; k++) begin
                p = (last + k) % N;
                if (!any && cl[p].size() > 0) begin
                    len = cl[p].pop_front();
                    f   = cf[p].pop_front();
                    exp_port.push_back(p);
                    exp_fid.push_back(f);
                    exp_len.push_back(len > ML ? ML : len);
                    if (len > ML) begin exp_st[p]++; exp_tr++; end
                    else exp_sf[p]++;
                    any  = 1'b1;
                    last = p;
                end
            end
        end while (any);
    endtask

    task automatic drive_inputs();
        int v;
        for (int p = 0; p < N; p++) begin
            if (sq[p].size() > 0) begin
                v = sq[p][0];
                bus.s_axis_tvalid[p]      = 1'b1;
                bus.s_axis_tdata[p*8 +: 8] = v[7:0];
                bus.s_axis_tlast[p]       = v[8];
            end else begin
                bus.s_axis_tvalid[p]      = 1'b0;
                bus.s_axis_tdata[p*8 +: 8] = 8'd0;
                bus.s_axis_tlast[p]       = 1'b0;
            end
        end
        bus.m_axis_tready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic clear_tb();
        for (int p = 0; p < N; p++) begin
            sq[p].delete();
            mdl_len[p].delete();
            mdl_fid[p].delete();
        end
        exp_port.delete();
        exp_fid.delete();
        exp_len.delete();
        mon_fr = 0; mon_bi = 0; out_bytes = 0; trunc_cnt = 0; obs_order = 0; cyc = 0;
        prev_end_hs = 1'b0; prev_trunc_evt = 1'b0;
    endtask

    // One clock: sample and check at negedge, then advance sources just after posedge.
    task automatic step();
        logic [N-1:0] shs;
        logic mhs, src_last;
        int v;
        @(negedge clk);
        shs = bus.s_axis_tvalid & bus.s_axis_tready;
        mhs = bus.m_axis_tvalid & bus.m_axis_tready;
        src_last = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (shs[p] && sq[p].size() > 0) begin
                v = sq[p][0];
                src_last = src_last | v[8];
            end
        end
        chk("ready_non_owner", 32'(bus.s_axis_tready & ~grant), 0);
        if (bus.m_axis_tvalid) chk("ready_mirror", 32'(|(bus.s_axis_tready & grant)), 32'(bus.m_axis_tready));
        if (prev_end_hs) chk("idle_bubble", 32'({grant, bus.m_axis_tvalid}), 0);
        chk("trunc_pulse", 32'(trunc_pulse), 32'(prev_trunc_evt));
        if (trunc_pulse) trunc_cnt++;
        if (cyc == 0) chk("grant_lat0", 32'(grant), 0);
        if (cyc == 1 && exp_port.size() > 0) chk("grant_lat1", 32'(grant), 32'(1 << exp_port[0]));
        if (mhs) begin
            if (mon_fr >= exp_port.size()) begin
                chk("extra_beat", 32'(mon_fr), 32'(exp_port.size() - 1));
            end else begin
                if (mon_bi == 0 && grant[1] && mon_fr < 31) obs_order |= (1 << mon_fr);
                chk("beat_grant", 32'(grant), 32'(1 << exp_port[mon_fr]));
                chk("beat_data", 32'(bus.m_axis_tdata), 32'(dat(exp_port[mon_fr], exp_fid[mon_fr], mon_bi)));
                chk("beat_tlast", 32'(bus.m_axis_tlast), 32'(mon_bi == exp_len[mon_fr] - 1));
            end
            out_bytes++;
            if (bus.m_axis_tlast) begin mon_fr++; mon_bi = 0; end
            else mon_bi++;
        end
        prev_end_hs    = mhs && bus.m_axis_tlast && src_last;
        prev_trunc_evt = mhs && bus.m_axis_tlast && !src_last;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) if (shs[p] && sq[p].size() > 0) void'(sq[p].pop_front());
        drive_inputs();
        cyc++;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_tb();
        rdy_pct = 0;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_mvalid", 32'(bus.m_axis_tvalid), 0);
        chk("rst_sready", 32'(bus.s_axis_tready), 0);
        chk("rst_trunc", 32'(trunc_pulse), 0);
        chk("rst_stats", 32'(stat_frames | stat_truncs), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic bit sources_empty();
        for (int p = 0; p < N; p++) if (sq[p].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run(input int rdy);
        int budget, bytes;
        bytes = 0;
        for (int p = 0; p < N; p++) bytes += sq[p].size();
        budget = 100 + bytes * 4 * 100 / rdy;
        rdy_pct = rdy;
        cyc = 0;
        drive_inputs();
        while (!(sources_empty() && mon_fr == exp_port.size())) begin
            if (cyc >= budget) begin
                fail_now("run_timeout");
                break;
            end
            step();
        end
        repeat (2) step();
    endtask

    task automatic stats_check();
        for (int p = 0; p < N; p++) begin
`ifdef ARB_STATS_EN
            chk("stat_frames", 32'(stat_frames[p*16 +: 16]), 32'(exp_sf[p]));
            chk("stat_truncs", 32'(stat_truncs[p*16 +: 16]), 32'(exp_st[p]));
`else
            chk("stat_frames_off", 32'(stat_frames[p*16 +: 16]), 0);
            chk("stat_truncs_off", 32'(stat_truncs[p*16 +: 16]), 0);
`endif
        end
    endtask

    initial begin
        int nf, len, rdy;
        rst = 1'b1;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b0;
        for (int p = 0; p < N; p++) fid_ctr[p] = 0;

        //       len0  len1  nfr rdy  frames bytes truncs order(bit k = port of frame k)
        vt[0] = '{60,   0,    1,  100, 1,     60,   0,     0};
        vt[1] = '{64,   64,   3,  100, 6,     384,  0,     32'h2A};
        vt[2] = '{0,    1600, 1,  100, 1,     1514, 1,     32'h01};
        vt[3] = '{1514, 0,    1,  100, 1,     1514, 0,     0};
        vt[4] = '{100,  0,    1,  50,  1,     100,  0,     0};
        vt[5] = '{1,    1,    2,  100, 4,     4,    0,     32'h0A};
        vt[6] = '{1515, 3,    1,  70,  2,     1517, 1,     32'h02};

        for (int v = 0; v < 7; v++) begin
            reset_dut();
            for (int f = 0; f < vt[v].nfr; f++) begin
                if (vt[v].len0 > 0) load_frame(0, vt[v].len0);
                if (vt[v].len1 > 0) load_frame(1, vt[v].len1);
            end
            build_expected();
            run(vt[v].rdy);
            chk("vec_frames", 32'(mon_fr), 32'(vt[v].e_frames));
            chk("vec_bytes", 32'(out_bytes), 32'(vt[v].e_bytes));
            chk("vec_truncs", 32'(trunc_cnt), 32'(vt[v].e_truncs));
            chk("vec_order", 32'(obs_order), 32'(vt[v].e_order));
            stats_check();
        end

        // Reset at byte 30 of port 1's frame, after port 0 already had a turn.
        reset_dut();
        load_frame(0, 10);
        load_frame(1, 100);
        build_expected();
        rdy_pct = 100;
        cyc = 0;
        drive_inputs();
        while (!(mon_fr == 1 && mon_bi == 30)) begin
            if (cyc >= 2000) begin
                fail_now("midrst_wait");
                break;
            end
            step();
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_mvalid", 32'(bus.m_axis_tvalid), 0);
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_sready", 32'(bus.s_axis_tready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_tb();
        load_frame(0, 5);
        load_frame(1, 5);
        build_expected();
        run(100);
        chk("midrst_frames", 32'(mon_fr), 2);
        chk("midrst_order", 32'(obs_order), 32'h02);

        // Random frame mixes with random backpressure.
        for (int it = 0; it < 4; it++) begin
            reset_dut();
            for (int p = 0; p < N; p++) begin
                nf = $urandom_range(3, 1);
                for (int f = 0; f < nf; f++) begin
                    len = ($urandom_range(9) == 0) ? $urandom_range(1530, 1500) : $urandom_range(120, 1);
                    load_frame(p, len);
                end
            end
            build_expected();
            rdy = $urandom_range(100, 30);
            run(rdy);
            chk("rnd_frames", 32'(mon_fr), 32'(exp_port.size()));
            chk("rnd_truncs", 32'(trunc_cnt), 32'(exp_tr));
            stats_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/net_tx_frame_arbiter.md
Name: net_tx_frame_arbiter

Overview:
Frame-granular round-robin arbiter that shares the TEMAC 8-bit transmit AXI-Stream between NUM_REQ requesters, for example the MicroBlaze packet path and the encryption accelerator egress.
- Sits in the net_axis_clk domain directly in front of the TEMAC tx_axis port.
- Holds a grant for a whole frame, so frames never interleave.
- Enforces a maximum frame length by truncating and draining oversized frames.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
MAX_LEN, 1514, maximum bytes forwarded per frame (excluding FCS; the TEMAC appends FCS)
CNT_W, $clog2(MAX_LEN+1), byte counter width (derived, not overridden)

Ports:
net_axis_clk  in  1  stream clock; all logic in this domain
net_axis_rst  in  1  synchronous reset, active-high
s_axis_tdata  in  NUM_REQ*8  requester bytes, port i at [8i+7:8i]
s_axis_tvalid  in  NUM_REQ  per-requester valid
s_axis_tlast  in  NUM_REQ  per-requester end of frame
s_axis_tready  out  NUM_REQ  per-requester ready
m_axis_tdata  out  8  to TEMAC tx_axis_tdata
m_axis_tvalid  out  1  to TEMAC tx_axis_tvalid
m_axis_tlast  out  1  to TEMAC tx_axis_tlast
m_axis_tready  in  1  from TEMAC tx_axis_tready
grant  out  NUM_REQ  one-hot current owner; 0 in IDLE
trunc_pulse  out  1  one-cycle pulse when a frame was truncated
stat_frames  out  NUM_REQ*16  per-port forwarded-frame count (ARB_STATS_EN)
stat_truncs  out  NUM_REQ*16  per-port truncation count (ARB_STATS_EN)

Behaviour:
- Reset (sync, net_axis_rst=1 at clock edge):
  - state=IDLE, last_grant=NUM_REQ-1 (port 0 wins first), byte_cnt=0, grant=0, trunc_pulse=0, stats=0.
  - All s_axis_tready=0, m_axis_tvalid=0.
  - A reset mid-frame aborts immediately; the TEMAC sees the frame end without tlast. This is accepted.
- IDLE:
  - Outputs quiet.
  - If any s_axis_tvalid is set, pick the first valid port searching last_grant+1, last_grant+2, ... (modulo NUM_REQ).
  - Register the pick into grant and go to PASS. This costs 1 cycle of arbitration latency.
  - With no valid input, stay in IDLE.
- PASS (owner g):
  - Combinational pass-through: m_axis_tdata/tvalid/tlast = s[g]; s_axis_tready[g] = m_axis_tready; all other readies 0. Zero added latency.
  - byte_cnt increments on each m handshake.
  - Handshake with s tlast: go to IDLE, last_grant=g, byte_cnt=0.
  - Handshake with byte_cnt==MAX_LEN-1 and no s tlast: m_axis_tlast is forced 1 on that beat. Then go to DRAIN; trunc_pulse=1 in the following cycle.
  - Real tlast exactly on beat MAX_LEN is a normal end, not a truncation.
- DRAIN (owner g):
  - m_axis_tvalid=0, s_axis_tready[g]=1, other readies 0. Discard beats until an s tlast handshake.
  - Then go to IDLE, last_grant=g, byte_cnt=0.
  - grant stays asserted through DRAIN.
- Minimum one IDLE bubble between frames. At 100 Mb/s RMII the byte rate is far below clock rate, so this costs nothing.
- Fairness: all ports continuously valid produces strict rotation 0,1,..,NUM_REQ-1,0.
- Sources hold tvalid/tdata stable until handshake, per AXIS rules. The arbiter never deasserts m_axis_tvalid mid-beat on its own.
- A 1-byte frame (tvalid and tlast on the first beat) is legal and is forwarded.

Optional Feature:
ARB_STATS_EN
- Defined: per-port 16-bit saturating counters.
  - stat_frames increments on each normal tlast handshake in PASS.
  - stat_truncs increments when entering DRAIN.
  - Both counters are cleared by reset.
- Undefined: no counter logic; stat_frames and stat_truncs are tied to 0. Ports remain for a stable interface.

Decomposition:
- Package net_arb_pkg:
  - state enum (ARB_IDLE, ARB_PASS, ARB_DRAIN)
  - constants NUM_REQ_MAX=4, STAT_W=16
  - default MAX_LEN
- Sub-module net_rr_picker: combinational round-robin picker.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot pick and a valid flag.
  - Reused by the future rx-side demux.

Test Plan:
- Reset, then port 0 sends a 60-byte frame with m_axis_tready=1 -> grant=01 one cycle after tvalid; 60 bytes out in order; tlast on byte 60; state returns to IDLE.
- Ports 0 and 1 both hold 3 back-to-back 64-byte frames -> output frame order 0,1,0,1,0,1; no interleaving; one idle cycle between frames.
- Port 1 sends a 1600-byte frame, MAX_LEN=1514 -> 1514 bytes out with tlast on byte 1514; trunc_pulse one cycle; remaining 86 bytes consumed with m_axis_tvalid=0; stat_truncs[1]=1 when ARB_STATS_EN is defined.
- Random m_axis_tready backpressure (50%) during a 100-byte frame from port 0 -> byte sequence intact; s_axis_tready[0] mirrors m_axis_tready; port 1 ready stays 0.
- Assert net_axis_rst at byte 30 of a frame -> next cycle m_axis_tvalid=0, grant=0, all readies 0; first grant after reset goes to port 0.
- Frame of exactly 1514 bytes with tlast -> forwarded untruncated; trunc_pulse stays 0; stat_frames increments.
